// File: rtl/cmd_stream_arbiter.sv
// cmd_stream_arbiter
//   Shares one 32-bit command stream between two requesters. Whole packets are
//   granted round-robin and serialized onto dn_data/dn_enable. Result words from
//   the interface go back only to the requester that owns the in-flight packet.
//   The next grant is held until all results of the current packet have drained.
//
// Ports
//   clk, clear            : clock, synchronous active-high reset
//   reqN_data/valid/last  : requester N command word, valid, last word of packet
//   reqN_ready            : requester N word accepted this cycle
//   dn_data/dn_enable     : registered word and enable toward the interface
//   dn_ready              : interface can take a word
//   up_data/up_y_valid    : result word from the interface
//   up_out_count(_valid)  : number of results the current packet will produce
//   rsp_data/rsp_valid    : routed result word, one-hot per requester
//   owner, busy           : current grant index, arbiter not idle
//   timeout_err           : one-cycle pulse when a drain is aborted
module cmd_stream_arbiter #(
    parameter int SETTLE_CYC  = 3,
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] req0_data,
    input  logic        req0_valid,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic [31:0] req1_data,
    input  logic        req1_valid,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic [31:0] dn_data,
    output logic        dn_enable,
    input  logic        dn_ready,
    input  logic [31:0] up_data,
    input  logic        up_y_valid,
    input  logic [31:0] up_out_count,
    input  logic        up_out_count_valid,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_valid,
    output logic        owner,
    output logic        busy,
    output logic        timeout_err
);

    localparam int ST_W = $clog2(SETTLE_CYC) + 1;
    localparam int DT_W = $clog2(TIMEOUT_CYC) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        SETTLE = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [31:0]       r_dn_data;
    logic              r_dn_enable;
    logic [31:0]       r_rsp_data;
    logic [1:0]        r_rsp_valid;
    logic              r_owner;
    logic              r_last_grant;
    logic              r_busy;
    logic              r_timeout_err;
    logic [CNT_W-1:0]  r_exp_cnt;
    logic [CNT_W-1:0]  r_rcv_cnt;
    logic [ST_W-1:0]   r_settle_t;
    logic [DT_W-1:0]   r_drain_t;

    logic [1:0]        w_valid;
    logic [1:0]        w_req_ready;
    logic              w_xfer;
    logic              w_last_sel;
    logic [31:0]       w_word_sel;
    logic              w_active;
    logic              w_do_grant;
    logic              w_grant_idx;
    logic              w_timeout;
    logic              w_unused_bits;

    assign w_valid    = {req1_valid, req0_valid};
    assign w_word_sel = r_owner ? req1_data : req0_data;
    assign w_last_sel = r_owner ? req1_last : req0_last;
    assign w_active   = (r_state != IDLE);
    assign w_unused_bits = &{1'b0, up_out_count[31:CNT_W]};

    // Only the owner sees ready, and only while its packet is being sent.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign w_req_ready[gi] = (r_state == SEND) && (r_owner == 1'(gi))
                                     && w_valid[gi] && dn_ready;
        end
    endgenerate

    assign w_xfer     = |w_req_ready;
    assign req0_ready = w_req_ready[0];
    assign req1_ready = w_req_ready[1];

    always_comb begin
        w_state_next = r_state;
        w_do_grant   = 1'b0;
        w_grant_idx  = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_valid) begin
                    w_do_grant   = 1'b1;
                    // Contention goes to whoever did not win last time.
                    w_grant_idx  = (&w_valid) ? ~r_last_grant : w_valid[1];
                    w_state_next = SEND;
                end
            end
            SEND: begin
                if (w_xfer && w_last_sel) begin
                    w_state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (r_settle_t == ST_W'(SETTLE_CYC - 1)) begin
                    if ((r_exp_cnt != '0) && (r_rcv_cnt < r_exp_cnt)) begin
                        w_state_next = DRAIN;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (r_rcv_cnt == r_exp_cnt) begin
                    w_state_next = IDLE;
                end else if (r_drain_t == DT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_next = IDLE;
                    w_timeout    = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state       <= IDLE;
            r_dn_data     <= '0;
            r_dn_enable   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_valid   <= '0;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_exp_cnt     <= '0;
            r_rcv_cnt     <= '0;
            r_settle_t    <= '0;
            r_drain_t     <= '0;
        end else begin
            r_state       <= w_state_next;
            r_busy        <= (w_state_next != IDLE);
            r_dn_enable   <= 1'b1;
            // No transfer means a NOP header word keeps the pipeline moving.
            r_dn_data     <= w_xfer ? w_word_sel : 32'h0;
            r_timeout_err <= w_timeout;
            r_settle_t    <= (r_state == SETTLE) ? r_settle_t + ST_W'(1) : '0;
            r_drain_t     <= (r_state == DRAIN)  ? r_drain_t  + DT_W'(1) : '0;

            if (w_do_grant) begin
                r_owner      <= w_grant_idx;
                r_last_grant <= w_grant_idx;
                r_exp_cnt    <= '0;
                r_rcv_cnt    <= '0;
            end

            if (w_active && up_out_count_valid) begin
                r_exp_cnt <= up_out_count[CNT_W-1:0];
            end

            if (w_active && up_y_valid) begin
                r_rsp_data  <= up_data;
                r_rsp_valid <= 2'b01 << r_owner;
                if (r_rcv_cnt != {CNT_W{1'b1}}) begin
                    r_rcv_cnt <= r_rcv_cnt + CNT_W'(1);
                end
            end else begin
                r_rsp_valid <= '0;
            end
        end
    end

    assign dn_data     = r_dn_data;
    assign dn_enable   = r_dn_enable;
    assign rsp_data    = r_rsp_data;
    assign rsp_valid   = r_rsp_valid;
    assign owner       = r_owner;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
module tb_cmd_stream_arbiter;

    localparam int SETTLE_CYC  = 3;
    localparam int TIMEOUT_CYC = 16;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] rq_data [2];
    logic        rq_valid[2];
    logic        rq_last [2];
    logic        rdy0, rdy1;
    logic [31:0] dn_data;
    logic        dn_enable;
    logic        dn_ready;
    logic [31:0] up_data;
    logic        up_y_valid;
    logic [31:0] up_out_count;
    logic        up_out_count_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_valid;
    logic        owner;
    logic        busy;
    logic        timeout_err;

    cmd_stream_arbiter #(
        .SETTLE_CYC (SETTLE_CYC),
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CNT_W      (16)
    ) dut (
        .clk               (clk),
        .clear             (clear),
        .req0_data         (rq_data[0]),
        .req0_valid        (rq_valid[0]),
        .req0_last         (rq_last[0]),
        .req0_ready        (rdy0),
        .req1_data         (rq_data[1]),
        .req1_valid        (rq_valid[1]),
        .req1_last         (rq_last[1]),
        .req1_ready        (rdy1),
        .dn_data           (dn_data),
        .dn_enable         (dn_enable),
        .dn_ready          (dn_ready),
        .up_data           (up_data),
        .up_y_valid        (up_y_valid),
        .up_out_count      (up_out_count),
        .up_out_count_valid(up_out_count_valid),
        .rsp_data          (rsp_data),
        .rsp_valid         (rsp_valid),
        .owner             (owner),
        .busy              (busy),
        .timeout_err       (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: round-robin pointer and expected streams.
    int          m_last = 1;
    logic [31:0] exp_words[$];
    logic [33:0] exp_rsp[$];
    logic [31:0] obs_words[$];
    logic [33:0] obs_rsp[$];
    int          n_to = 0;
    int          r1_viol = 0;
    bit          p0_done = 1'b0;
    bit          r1_guard = 1'b0;
    int          sent_cnt[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Observation of everything that leaves the DUT.
    always @(negedge clk) begin
        if (!clear) begin
            if (dn_data != 32'h0) obs_words.push_back(dn_data);
            if (rsp_valid != 2'b00) obs_rsp.push_back({rsp_valid, rsp_data});
            if (timeout_err) n_to++;
        end
    end

    always @(posedge clk) begin
        if (r1_guard && !p0_done && rdy1) r1_viol++;
    end

    function automatic int pick(input bit v0, input bit v1);
        int g;
        if (v0 && v1) g = 1 - m_last;
        else          g = v1 ? 1 : 0;
        m_last = g;
        return g;
    endfunction

    task automatic send_pkt(input int n, input logic [31:0] w[$], output bit first_rdy, output bit ok);
        int  idx = 0;
        int  cyc = 0;
        bit  r;
        first_rdy = 1'b0;
        while (idx < w.size() && cyc < 400) begin
            @(negedge clk);
            rq_data[n]  = w[idx];
            rq_valid[n] = 1'b1;
            rq_last[n]  = (idx == w.size() - 1);
            #1;
            r = (n == 0) ? rdy0 : rdy1;
            if (cyc == 0) first_rdy = r;
            @(posedge clk);
            cyc++;
            if (r) begin
                idx++;
                sent_cnt[n]++;
            end
        end
        #1;
        rq_valid[n] = 1'b0;
        rq_last[n]  = 1'b0;
        if (n == 0) p0_done = 1'b1;
        ok = (idx == w.size());
    endtask

    // Plays the interface: once the packet's last word has been seen,
    // report the result count and return the result words.
    task automatic respond(input int endi, input int cnt, input logic [31:0] d[$], output bit ok);
        int cyc = 0;
        ok = 1'b0;
        while (cyc < 400) begin
            @(negedge clk); #2;
            cyc++;
            if (obs_words.size() >= endi) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        if (cnt > 0) begin
            up_out_count       = ($urandom & 32'hFFFF_0000) | 32'(cnt);
            up_out_count_valid = 1'b1;
        end
        for (int k = 0; k < d.size(); k++) begin
            if (k > 0) begin
                @(negedge clk); #2;
                up_y_valid = 1'b0; up_out_count_valid = 1'b0;
                if ($urandom_range(0, 1) == 1) begin
                    @(negedge clk); #2;
                end
            end
            up_data    = d[k];
            up_y_valid = 1'b1;
        end
        @(negedge clk); #2;
        up_y_valid = 1'b0; up_out_count_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check(tag, busy, 0);
    endtask

    task automatic cmp_queues(input string tag);
        check({tag, "_nwords"}, obs_words.size(), exp_words.size());
        for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++)
            check({tag, "_word"}, obs_words[i], exp_words[i]);
        check({tag, "_nrsp"}, obs_rsp.size(), exp_rsp.size());
        for (int i = 0; i < exp_rsp.size() && i < obs_rsp.size(); i++)
            check({tag, "_rsp"}, obs_rsp[i], exp_rsp[i]);
        obs_words.delete(); exp_words.delete();
        obs_rsp.delete();   exp_rsp.delete();
    endtask

    task automatic run_round(input string tag, input bit v0, input bit v1,
                             input logic [31:0] p0[$], input logic [31:0] p1[$],
                             input logic [31:0] r0[$], input logic [31:0] r1[$]);
        int order[$];
        int endi[$];
        int acc = 0;
        bit ok0 = 1'b1, ok1 = 1'b1, okr = 1'b1, fr0 = 1'b0, fr1 = 1'b0;
        if (v0 && v1) begin
            order.push_back(pick(1'b1, 1'b1));
            order.push_back(1 - order[0]);
            m_last = order[1];
        end else begin
            order.push_back(pick(v0, v1));
        end
        foreach (order[k]) begin
            if (order[k] == 0) begin
                foreach (p0[j]) exp_words.push_back(p0[j]);
                foreach (r0[j]) exp_rsp.push_back({2'b01, r0[j]});
                acc += p0.size();
            end else begin
                foreach (p1[j]) exp_words.push_back(p1[j]);
                foreach (r1[j]) exp_rsp.push_back({2'b10, r1[j]});
                acc += p1.size();
            end
            endi.push_back(acc);
        end
        p0_done  = 1'b0;
        r1_viol  = 0;
        r1_guard = v0 && (order[0] == 0);
        fork
            begin if (v0) send_pkt(0, p0, fr0, ok0); end
            begin if (v1) send_pkt(1, p1, fr1, ok1); end
            begin
                bit okk;
                foreach (order[k]) begin
                    if (order[k] == 0) respond(endi[k], r0.size(), r0, okk);
                    else               respond(endi[k], r1.size(), r1, okk);
                    okr &= okk;
                end
            end
        join
        check({tag, "_send0"}, ok0, 1);
        check({tag, "_send1"}, ok1, 1);
        check({tag, "_resp"}, okr, 1);
        check({tag, "_grant_cycle_ready"}, {fr1, fr0}, 0);
        wait_idle({tag, "_idle"});
        if (r1_guard) check({tag, "_r1_ready_during_r0"}, r1_viol, 0);
        r1_guard = 1'b0;
        cmp_queues(tag);
    endtask

    initial begin
        logic [31:0] pa[$];
        logic [31:0] pb[$];
        logic [31:0] ra[$];
        logic [31:0] rb[$];
        logic [31:0] stray;
        bit          ok, fr;
        int          n;

        clear = 1'b1;
        rq_data[0] = '0; rq_data[1] = '0;
        rq_valid[0] = 1'b0; rq_valid[1] = 1'b0;
        rq_last[0] = 1'b0; rq_last[1] = 1'b0;
        sent_cnt[0] = 0; sent_cnt[1] = 0;
        dn_ready = 1'b1;
        up_data = '0; up_y_valid = 1'b0;
        up_out_count = '0; up_out_count_valid = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_enable", dn_enable, 0);
        check("rst_data", dn_data, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_owner", owner, 0);
        check("rst_timeout", timeout_err, 0);
        clear = 1'b0;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_enable", dn_enable, 1);
            check("idle_data", dn_data, 0);
            check("idle_rsp_valid", rsp_valid, 0);
            check("idle_busy", busy, 0);
            check("idle_ready", {rdy1, rdy0}, 0);
        end
        obs_words.delete(); obs_rsp.delete();

        // Directed single packet from requester 0 with two results.
        pa = '{32'h0001_0002, 32'h0000_0003, 32'h0000_0011, 32'h0000_0003, 32'h0000_0022};
        ra = '{32'h0000_00AA, 32'h0000_00BB};
        pb.delete(); rb.delete();
        run_round("single", 1'b1, 1'b0, pa, pb, ra, rb);

        // Both valid together, twice: 0 first each time.
        for (int rep = 0; rep < 2; rep++) begin
            pa.delete(); pb.delete(); ra.delete(); rb.delete();
            for (int j = 0; j < 3; j++) pa.push_back($urandom | 32'h1);
            for (int j = 0; j < 2; j++) pb.push_back($urandom | 32'h1);
            ra.push_back($urandom);
            rb.push_back($urandom); rb.push_back($urandom);
            run_round("both", 1'b1, 1'b1, pa, pb, ra, rb);
        end

        // Downstream stall of 3 cycles mid-packet.
        pa.delete();
        for (int j = 0; j < 5; j++) pa.push_back($urandom | 32'h1);
        n = pick(1'b1, 1'b0);
        foreach (pa[j]) exp_words.push_back(pa[j]);
        sent_cnt[0] = 0;
        fork
            send_pkt(0, pa, fr, ok);
            begin
                int c = 0;
                while (sent_cnt[0] < 2 && c < 100) begin
                    @(posedge clk); #2; c++;
                end
                check("stall_reach", sent_cnt[0] >= 2, 1);
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    dn_ready = 1'b0;
                    if (i > 0) check("stall_dn_data", dn_data, 0);
                    #1;
                    check("stall_ready", rdy0, 0);
                end
                @(negedge clk);
                check("stall_dn_data", dn_data, 0);
                dn_ready = 1'b1;
            end
        join
        check("stall_send", ok, 1);
        wait_idle("stall_idle");
        cmp_queues("stall");

        // Result-less packet returns to IDLE SETTLE_CYC cycles after transfer.
        pa = '{32'h0002_0050};
        n = pick(1'b1, 1'b0);
        exp_words.push_back(32'h0002_0050);
        send_pkt(0, pa, fr, ok);
        check("nores_send", ok, 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (!busy) break;
        end
        check("nores_settle_cycles", n, SETTLE_CYC);
        check("nores_timeout", n_to, 0);
        cmp_queues("nores");

        // Count 4 but one result: drain times out.
        pa = '{32'h0001_0004};
        n = pick(1'b1, 1'b0);
        exp_words.push_back(32'h0001_0004);
        send_pkt(0, pa, fr, ok);
        check("to_send", ok, 1);
        stray = $urandom;
        exp_rsp.push_back({2'b01, stray});
        up_out_count = 32'h0000_0004; up_out_count_valid = 1'b1;
        up_data = stray; up_y_valid = 1'b1;
        @(posedge clk); n = 1;
        #1;
        up_out_count_valid = 1'b0; up_y_valid = 1'b0;
        while (n < 60) begin
            @(posedge clk); n++;
            #1;
            if (timeout_err) break;
        end
        check("to_cycles", n, SETTLE_CYC + TIMEOUT_CYC);
        check("to_pulse", timeout_err, 1);
        check("to_busy", busy, 0);
        @(posedge clk); #1;
        check("to_single_pulse", timeout_err, 0);
        up_data = $urandom; up_y_valid = 1'b1;
        @(posedge clk); #1;
        up_y_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("to_count", n_to, 1);
        cmp_queues("timeout");

        // Randomized rounds.
        for (int rd = 0; rd < 10; rd++) begin
            int mask;
            mask = $urandom_range(1, 3);
            pa.delete(); pb.delete(); ra.delete(); rb.delete();
            for (int j = 0; j < $urandom_range(1, 4); j++) pa.push_back($urandom | 32'h1);
            for (int j = 0; j < $urandom_range(1, 4); j++) pb.push_back($urandom | 32'h1);
            for (int j = 0; j < $urandom_range(0, 3); j++) ra.push_back($urandom);
            for (int j = 0; j < $urandom_range(0, 3); j++) rb.push_back($urandom);
            run_round("rand", mask[0], mask[1], pa, pb, ra, rb);
        end

        check("total_timeouts", n_to, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cmd_stream_arbiter.md
Name: cmd_stream_arbiter

Overview:
- Shares the single 32-bit command stream of `data_interface` between two requesters.
- Grants whole command packets round-robin and serializes the granted packet onto the interface's `data_in`/`enable` bus.
- Returns the interface's result words (`data_out`/`y_valid`) only to the requester that owns the in-flight packet.
- Holds off the next grant until all results of the current packet have drained, so result ownership is never ambiguous.

Parameters:
- `SETTLE_CYC`, 3: cycles after a packet's last word to wait for `out_count_valid` before declaring the packet result-less.
- `TIMEOUT_CYC`, 1024: maximum cycles in DRAIN without completing; exceeding it aborts the drain.
- `CNT_W`, 16: width of the expected/received result counters (matches the header count field `[15:0]`).

Ports:
- `clk` in 1: global clock.
- `clear` in 1: synchronous active-high reset.
- `req0_data` in 32: requester 0 command word.
- `req0_valid` in 1: `req0_data` valid.
- `req0_last` in 1: final word of the packet.
- `req0_ready` out 1: word accepted this cycle.
- `req1_data` / `req1_valid` / `req1_last` / `req1_ready`: same as requester 0, for requester 1.
- `dn_data` out 32: word to interface `data_in`.
- `dn_enable` out 1: interface `enable`.
- `dn_ready` in 1: interface `ready`.
- `up_data` in 32: interface `data_out`.
- `up_y_valid` in 1: interface `y_valid`.
- `up_out_count` in 32: interface `out_count`; bits `[15:0]` used.
- `up_out_count_valid` in 1: interface `out_count_valid`.
- `rsp_data` out 32: routed result word.
- `rsp_valid` out 2: one-hot pulse, bit i = result for requester i.
- `owner` out 1: index of the current grant.
- `busy` out 1: state != IDLE.
- `timeout_err` out 1: one-cycle pulse on drain abort.

Behaviour:
- Reset (`clear`=1 at posedge):
  - State = IDLE.
  - `dn_data`=0, `dn_enable`=0, `rsp_data`=0, `rsp_valid`=0, `owner`=0, `busy`=0, `timeout_err`=0.
  - `last_grant`=1, so requester 0 wins first.
  - `exp_cnt`=0, `rcv_cnt`=0, timers=0.
  - Reset mid-packet abandons the packet. No recovery words are sent; the interface is reset by the same `clear`.
- `dn_enable`: registered. It goes to 1 on the first cycle after reset and stays 1, keeping the interface pipeline advancing. When no word is transferred, `dn_data` = 32'h0 (NOP header: type 0, count 0).
- States:
  - IDLE:
    - If exactly one `reqN_valid` is high, grant N.
    - If both are high, grant the requester != `last_grant`.
    - On grant: `owner`<=N, `last_grant`<=N, `exp_cnt`<=0, `rcv_cnt`<=0, next state SEND.
    - Requests are not accepted in the grant cycle: all `req_ready`=0 in IDLE.
  - SEND:
    - `req_ready[owner]` = `req_valid[owner]` & `dn_ready` (combinational). The non-owner's ready is 0.
    - On transfer: `dn_data`<=word, registered, so the interface sees it one cycle later.
    - On a transfer with `last`=1: `settle_t`<=0, next state SETTLE.
    - Requesters must present packets gap-free. A gap inserts a NOP word. The bench does not exercise gaps.
  - SETTLE: increments `settle_t` each cycle. When `settle_t`==`SETTLE_CYC`-1:
    - go to DRAIN if `exp_cnt`!=0 and `rcv_cnt`<`exp_cnt`;
    - otherwise go to IDLE.
  - DRAIN: exit to IDLE when `rcv_cnt`==`exp_cnt`. If `drain_t` reaches `TIMEOUT_CYC`-1 first, exit to IDLE and pulse `timeout_err`.
- Count capture: in SEND, SETTLE or DRAIN, `up_out_count_valid`=1 sets `exp_cnt`<=`up_out_count[15:0]`. A later pulse for the same packet overwrites the count.
- Result routing: in SEND, SETTLE or DRAIN, `up_y_valid`=1 produces, one cycle later, `rsp_data`=`up_data` and `rsp_valid`=1<<`owner`; `rcv_cnt` increments.
  - `up_y_valid` in IDLE is discarded; `rsp_valid` stays 0.
  - `rcv_cnt` saturates at all-ones.
- Simultaneous count and result events in one cycle: both take effect. The DRAIN exit compares the updated values on the next cycle.
- `busy` = (state != IDLE), registered.

Test Plan:
- Reset, then idle for 10 cycles:
  - `dn_enable`=1 from cycle 1; `dn_data`=0 throughout.
  - `rsp_valid`=0, `busy`=0, `req0_ready`=`req1_ready`=0.
- Single packet, requester 0: `{0x00010002, 0x00000003, 0x11, 0x00000003, 0x22}` with last on the final word, `dn_ready`=1.
  - Five words appear on `dn_data` in order, one cycle after each transfer.
  - Model out_count=2 and two `up_y_valid` pulses with data 0xAA and 0xBB.
  - `rsp_valid`=2'b01 twice carrying 0xAA then 0xBB; then IDLE.
- Both requesters valid in the same cycle after reset:
  - Requester 0 is granted first, then requester 1.
  - Repeating with both valid again grants 0 then 1 (round-robin).
  - `req1_ready` stays 0 throughout requester 0's packet.
- `dn_ready` low for 3 cycles mid-packet: `req0_ready`=0 and `dn_data`=0 during the stall; the word order is preserved.
- Packet with no type-1 header (e.g. `{0x00020050}` last):
  - Returns to IDLE exactly `SETTLE_CYC` cycles after the transfer.
  - No `rsp_valid`, no `timeout_err`.
- out_count=4 but only 1 result returned, `TIMEOUT_CYC`=16:
  - One `rsp_valid` pulse.
  - `timeout_err` pulses 16 cycles after DRAIN entry, then IDLE.
  - A stray later `up_y_valid` is dropped.
